// File: rtl/coeff_bus_master.sv
// -----------------------------------------------------------------------------
// coeff_bus_master
//
// Host-side initiator for the FIR coefficient-RAM bus. On a reload command it
// pulls N coefficients from an upstream source (req/valid handshake) and
// writes each one into the filter's coefficient RAM. Once loaded, every
// input-sample strobe triggers one read sweep of addresses 0..N-1.
//
// Optional build macro: COEFF_BUS_CHECKSUM_EN
//   When defined, adds oChecksum, the signed sum of all coefficients written
//   by the last completed load. When undefined, the port and its accumulator
//   do not exist.
//
// Ports:
//   iClk_12M          system clock, rising edge
//   iRst              asynchronous active-high reset
//   iStartUpdate      one-cycle reload command
//   iNumOfCoeff       N, sampled only when iStartUpdate is accepted
//   iSampleStrobe     one-cycle pulse per input sample, starts a read sweep
//   oCoeffReq         request for the next coefficient
//   iCoeffValid       iCoeffData is valid
//   iCoeffData        signed coefficient
//   oCoeffiUpdateFlag bus update flag
//   oCsnRam           bus chip select, active low
//   oWrnRam           bus write strobe, active low
//   oAddrRam          bus address
//   oWrDtRam          bus write data
//   oBusy             reload in progress
//   oFrameDone        one-cycle pulse after each read sweep
//   oErr              one-cycle pulse on an illegal command
//   oChecksum         (COEFF_BUS_CHECKSUM_EN only) sum of the last load
// -----------------------------------------------------------------------------
module coeff_bus_master #(
  parameter int P_ADDR_W    = 6,
  parameter int P_DATA_W    = 16,
  parameter int P_MAX_COEFF = 40
) (
  input  logic                       iClk_12M,
  input  logic                       iRst,
  input  logic                       iStartUpdate,
  input  logic [P_ADDR_W-1:0]        iNumOfCoeff,
  input  logic                       iSampleStrobe,
  output logic                       oCoeffReq,
  input  logic                       iCoeffValid,
  input  logic signed [P_DATA_W-1:0] iCoeffData,
  output logic                       oCoeffiUpdateFlag,
  output logic                       oCsnRam,
  output logic                       oWrnRam,
  output logic [P_ADDR_W-1:0]        oAddrRam,
  output logic signed [P_DATA_W-1:0] oWrDtRam,
  output logic                       oBusy,
  output logic                       oFrameDone,
  output logic                       oErr
`ifdef COEFF_BUS_CHECKSUM_EN
  ,
  output logic signed [21:0]         oChecksum
`endif
);

  // One extra bit so that a maximum equal to 2^P_ADDR_W is representable.
  localparam logic [P_ADDR_W:0] MAX_N = (P_ADDR_W + 1)'(P_MAX_COEFF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_WR_END,
    ST_RUN,
    ST_READ,
    ST_OUT,
    ST_RELOAD
  } state_t;

  state_t state_reg, state_next;

  logic [P_ADDR_W-1:0]        n_reg, n_next;
  logic [P_ADDR_W-1:0]        idx_reg, idx_next;
  logic                       loaded_reg, loaded_next;
  logic [P_ADDR_W-1:0]        addr_reg, addr_next;
  logic signed [P_DATA_W-1:0] data_reg, data_next;
  logic                       flag_reg, flag_next;
  logic                       csn_reg, csn_next;
  logic                       wrn_reg, wrn_next;
  logic                       req_reg, req_next;
  logic                       busy_reg, busy_next;
  logic                       done_reg, done_next;
  logic                       err_reg, err_next;
  logic                       legal_n;

`ifdef COEFF_BUS_CHECKSUM_EN
  logic signed [21:0] acc_reg, acc_next;
  logic signed [21:0] checksum_reg, checksum_next;
`endif

  assign legal_n = (iNumOfCoeff != '0) && ({1'b0, iNumOfCoeff} <= MAX_N);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_reg    <= ST_IDLE;
      n_reg        <= '0;
      idx_reg      <= '0;
      loaded_reg   <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      flag_reg     <= 1'b0;
      csn_reg      <= 1'b1;
      wrn_reg      <= 1'b1;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef COEFF_BUS_CHECKSUM_EN
      acc_reg      <= '0;
      checksum_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      idx_reg      <= idx_next;
      loaded_reg   <= loaded_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      flag_reg     <= flag_next;
      csn_reg      <= csn_next;
      wrn_reg      <= wrn_next;
      req_reg      <= req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
`ifdef COEFF_BUS_CHECKSUM_EN
      acc_reg      <= acc_next;
      checksum_reg <= checksum_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    n_next      = n_reg;
    idx_next    = idx_reg;
    loaded_next = loaded_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    flag_next   = 1'b0;
    csn_next    = 1'b1;
    wrn_next    = 1'b1;
    req_next    = 1'b0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
`ifdef COEFF_BUS_CHECKSUM_EN
    acc_next      = acc_reg;
    checksum_next = checksum_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        // Sample strobes are meaningless until a coefficient set exists.
        if (iStartUpdate) begin
          if (legal_n) begin
            n_next     = iNumOfCoeff;
            idx_next   = '0;
            state_next = ST_FETCH;
`ifdef COEFF_BUS_CHECKSUM_EN
            acc_next   = '0;
`endif
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        // The handshake uses the registered request so a coefficient is
        // only taken while the request is visible to the source.
        if (iCoeffValid && req_reg) begin
          data_next  = iCoeffData;
          addr_next  = idx_reg;
          state_next = ST_WRITE;
        end
      end

      ST_WRITE: begin
        idx_next = idx_reg + 1'b1;
`ifdef COEFF_BUS_CHECKSUM_EN
        acc_next = acc_reg + 22'(data_reg);
`endif
        if (idx_reg == n_reg - 1'b1) begin
          addr_next  = '0;
          data_next  = '0;
          state_next = ST_WR_END;
        end else begin
          state_next = ST_FETCH;
        end
      end

      ST_WR_END: begin
        loaded_next   = 1'b1;
        state_next    = ST_RUN;
`ifdef COEFF_BUS_CHECKSUM_EN
        checksum_next = acc_reg;
`endif
      end

      ST_RUN: begin
        // A reload command takes priority; a coincident strobe is dropped.
        if (iStartUpdate) begin
          if (legal_n) begin
            n_next     = iNumOfCoeff;
            state_next = ST_RELOAD;
`ifdef COEFF_BUS_CHECKSUM_EN
            acc_next   = '0;
`endif
          end else begin
            err_next = 1'b1;
          end
        end else if (iSampleStrobe && loaded_reg) begin
          addr_next  = '0;
          state_next = ST_READ;
        end
      end

      ST_READ: begin
        // Commands during a sweep are flagged but never disturb it.
        if (iStartUpdate || iSampleStrobe) begin
          err_next = 1'b1;
        end
        if (addr_reg == n_reg - 1'b1) begin
          state_next = ST_OUT;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end

      ST_OUT: begin
        addr_next  = '0;
        state_next = ST_RUN;
      end

      ST_RELOAD: begin
        idx_next   = '0;
        state_next = ST_FETCH;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Bus pattern is decoded from the state being entered, so it is
    // registered together with the state and has no input-to-output path.
    case (state_next)
      ST_FETCH: begin
        flag_next = 1'b1;
        wrn_next  = 1'b0;
        req_next  = 1'b1;
        busy_next = 1'b1;
      end
      ST_WRITE: begin
        flag_next = 1'b1;
        csn_next  = 1'b0;
        wrn_next  = 1'b0;
        busy_next = 1'b1;
      end
      ST_WR_END: begin
        busy_next = 1'b1;
      end
      ST_READ: begin
        csn_next = 1'b0;
      end
      ST_OUT: begin
        done_next = 1'b1;
      end
      ST_RELOAD: begin
        flag_next = 1'b1;
        wrn_next  = 1'b0;
        busy_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign oCoeffReq         = req_reg;
  assign oCoeffiUpdateFlag = flag_reg;
  assign oCsnRam           = csn_reg;
  assign oWrnRam           = wrn_reg;
  assign oAddrRam          = addr_reg;
  assign oWrDtRam          = data_reg;
  assign oBusy             = busy_reg;
  assign oFrameDone        = done_reg;
  assign oErr              = err_reg;
`ifdef COEFF_BUS_CHECKSUM_EN
  assign oChecksum         = checksum_reg;
`endif

endmodule
